// File: rtl/next_pc_unit_if.sv
// Next-PC bus: program-counter feedback and control-flow requests in, next PC and
// fetch-side status out. The front end drives it as master; next_pc_unit is the slave.
interface next_pc_unit_if #(
    parameter int unsigned D    = 12,
    parameter int unsigned OFFW = 8,
    parameter int unsigned CW   = 16
);
    logic [D-1:0]    pc_out;
    logic [D-1:0]    pc_added;
    logic            branch;
    logic [OFFW-1:0] branch_offset;
    logic            jump;
    logic            call;
    logic            ret;
    logic [D-1:0]    jump_target;
    logic            stall;
    logic            halt_req;

    logic [D-1:0]    pc_in;
    logic            halted;
    logic            stack_empty;
    logic            stack_full;
    logic            stack_error;
    logic [CW-1:0]   cycle_count;

    modport master (
        output pc_out, pc_added, branch, branch_offset, jump, call, ret, jump_target,
               stall, halt_req,
        input  pc_in, halted, stack_empty, stack_full, stack_error, cycle_count
    );

    modport slave (
        input  pc_out, pc_added, branch, branch_offset, jump, call, ret, jump_target,
               stall, halt_req,
        output pc_in, halted, stack_empty, stack_full, stack_error, cycle_count
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection and control-flow unit. Chooses the PC that program_counter
// registers on the next edge, and owns the RUN/HALTED state, the return-address
// stack, the sticky stack error and the retired-cycle counter.
module next_pc_unit #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OFFW  = 8,
    parameter int unsigned CW    = 16
) (
    input logic           clock,
    input logic           reset,
    next_pc_unit_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = AW + 1;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } state_e;

    // Source of the next PC, decided once per cycle by request priority.
    typedef enum logic [2:0] {
        SrcZero,
        SrcHold,
        SrcAdded,
        SrcTop,
        SrcTarget,
        SrcBranch
    } src_e;

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [D-1:0]  stack_q [DEPTH];

    src_e          src;
    logic          push;
    logic          pop;
    logic          err_set;
    logic          retire;
    logic          empty;
    logic          full;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [D-1:0]  top_entry;
    logic [D-1:0]  offset_ext;
    logic [D-1:0]  branch_target;
    logic [D-1:0]  pc_next;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DW'(DEPTH));
    assign top_idx  = AW'(depth_q - DW'(1));
    assign push_idx = AW'(depth_q);

    assign top_entry     = stack_q[top_idx];
    // Size cast of a signed value sign-extends; the add then wraps modulo 2^D.
    assign offset_ext    = D'($signed(bus.branch_offset));
    assign branch_target = bus.pc_out + offset_ext;

    // Priority decision: PC source, stack operation, error and retire strobes.
    always_comb begin
        src     = SrcAdded;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        retire  = 1'b0;
        if (reset) begin
            src     = SrcZero;
            state_d = StRun;
        end else if (state_q == StHalted) begin
            src = SrcHold;
        end else if (bus.halt_req) begin
            // The halting instruction is not retired; PC holds.
            src     = SrcHold;
            state_d = StHalted;
        end else if (bus.stall) begin
            src = SrcHold;
        end else begin
            retire = 1'b1;
            if (bus.ret) begin
                if (!empty) begin
                    src = SrcTop;
                    pop = 1'b1;
                end else begin
                    src     = SrcAdded;
                    err_set = 1'b1;
                end
            end else if (bus.call) begin
                if (!full) begin
                    src  = SrcTarget;
                    push = 1'b1;
                end else begin
                    src     = SrcAdded;
                    err_set = 1'b1;
                end
            end else if (bus.jump) begin
                src = SrcTarget;
            end else if (bus.branch) begin
                src = SrcBranch;
            end else begin
                src = SrcAdded;
            end
        end
    end

    // Next-PC multiplexer driven by the decided source.
    always_comb begin
        pc_next = bus.pc_added;
        unique case (src)
            SrcZero:   pc_next = '0;
            SrcHold:   pc_next = bus.pc_out;
            SrcAdded:  pc_next = bus.pc_added;
            SrcTop:    pc_next = top_entry;
            SrcTarget: pc_next = bus.jump_target;
            SrcBranch: pc_next = branch_target;
            default:   pc_next = bus.pc_added;
        endcase
    end

    // Next values for depth, sticky error and retired-cycle counter.
    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        count_d = count_q;
        if (push) begin
            depth_d = depth_q + DW'(1);
        end else if (pop) begin
            depth_d = depth_q - DW'(1);
        end
        if (err_set) begin
            err_d = 1'b1;
        end
        if (retire) begin
            count_d = count_q + CW'(1);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            depth_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Return-stack storage; entries above the depth are don't-care, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            stack_q[push_idx] <= bus.pc_added;
        end
    end

    assign bus.pc_in       = pc_next;
    assign bus.halted      = (state_q == StHalted);
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.stack_error = err_q;
    assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios followed by random
// request mixes, all compared against a queue-based reference model.
module tb_next_pc_unit;
    localparam int unsigned D     = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OFFW  = 8;
    localparam int unsigned CW    = 16;

    logic clock;
    logic reset;

    next_pc_unit_if #(.D(D), .OFFW(OFFW), .CW(CW)) bus ();

    next_pc_unit #(.D(D), .DEPTH(DEPTH), .OFFW(OFFW), .CW(CW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;

    // Reference model state.
    logic [D-1:0]  m_pc;
    logic [D-1:0]  m_stack [$];
    logic          m_halted;
    logic          m_err;
    logic [CW-1:0] m_count;
    logic [D-1:0]  e_pc;

    // Inputs of the current cycle, kept for the model update at the edge.
    logic          c_rst, c_br, c_jmp, c_cl, c_rt, c_stl, c_hlt;
    logic [OFFW-1:0] c_off;
    logic [D-1:0]  c_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict pc_in and compare all outputs.
    task automatic apply(input logic rst, input logic br, input logic [OFFW-1:0] off,
                         input logic jmp, input logic cl, input logic rt,
                         input logic [D-1:0] tgt, input logic stl, input logic hlt);
        int s;
        c_rst = rst; c_br = br; c_off = off; c_jmp = jmp; c_cl = cl; c_rt = rt;
        c_tgt = tgt; c_stl = stl; c_hlt = hlt;
        reset             = rst;
        bus.pc_out        = m_pc;
        bus.pc_added      = m_pc + 12'd1;
        bus.branch        = br;
        bus.branch_offset = off;
        bus.jump          = jmp;
        bus.call          = cl;
        bus.ret           = rt;
        bus.jump_target   = tgt;
        bus.stall         = stl;
        bus.halt_req      = hlt;
        #1;
        s = int'($signed(off));
        if (rst) e_pc = '0;
        else if (m_halted || hlt || stl) e_pc = m_pc;
        else if (rt) e_pc = (m_stack.size() > 0) ? m_stack[$] : m_pc + 12'd1;
        else if (cl) e_pc = (m_stack.size() < DEPTH) ? tgt : m_pc + 12'd1;
        else if (jmp) e_pc = tgt;
        else if (br) e_pc = D'(int'(m_pc) + s);
        else e_pc = m_pc + 12'd1;
        check("pc_in", 32'(bus.pc_in), 32'(e_pc));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("stack_empty", 32'(bus.stack_empty), 32'(m_stack.size() == 0));
        check("stack_full", 32'(bus.stack_full), 32'(m_stack.size() == DEPTH));
        check("stack_error", 32'(bus.stack_error), 32'(m_err));
        check("cycle_count", 32'(bus.cycle_count), 32'(m_count));
    endtask

    // Advance one clock edge and update the model with the same cycle's inputs.
    task automatic tick();
        @(posedge clock);
        if (c_rst) begin
            m_stack.delete();
            m_halted = 1'b0;
            m_err    = 1'b0;
            m_count  = '0;
        end else if (!m_halted) begin
            if (c_hlt) begin
                m_halted = 1'b1;
            end else if (!c_stl) begin
                m_count++;
                if (c_rt) begin
                    if (m_stack.size() > 0) void'(m_stack.pop_back());
                    else m_err = 1'b1;
                end else if (c_cl) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 12'd1);
                    else m_err = 1'b1;
                end
            end
        end
        m_pc = e_pc;
        @(negedge clock);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("rst_pc", 32'(bus.pc_in), 32'h0);
        tick();
    endtask

    task automatic do_call(input logic [D-1:0] tgt);
        apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, tgt, 1'b0, 1'b0);
    endtask

    task automatic do_ret();
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_pc     = '0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_count  = '0;
        reset    = 1'b1;
        @(negedge clock);

        // Reset then sequential walk.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            idle();
            check("seq_pc", 32'(bus.pc_in), 32'(i));
            tick();
        end
        idle();
        check("seq_count", 32'(bus.cycle_count), 32'd10);
        check("seq_empty", 32'(bus.stack_empty), 32'd1);
        check("seq_halted", 32'(bus.halted), 32'd0);
        tick();

        // Branch wrap in both directions.
        m_pc = 12'h002;
        apply(1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("br_neg", 32'(bus.pc_in), 32'hFFE);
        tick();
        apply(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("br_pos", 32'(bus.pc_in), 32'h003);
        tick();

        // Nested call/return.
        do_reset();
        m_pc = 12'h005;
        do_call(12'h100);
        check("call1", 32'(bus.pc_in), 32'h100);
        tick();
        do_call(12'h200);
        check("call2", 32'(bus.pc_in), 32'h200);
        tick();
        do_ret();
        check("ret1", 32'(bus.pc_in), 32'h101);
        tick();
        do_ret();
        check("ret2", 32'(bus.pc_in), 32'h006);
        tick();
        idle();
        check("ret_empty", 32'(bus.stack_empty), 32'd1);
        check("ret_noerr", 32'(bus.stack_error), 32'd0);
        tick();

        // Overflow then underflow.
        do_reset();
        do_call(12'h010); tick();
        do_call(12'h020); tick();
        do_call(12'h030); tick();
        do_call(12'h050); tick();
        do_call(12'h300);
        check("ovf_full", 32'(bus.stack_full), 32'd1);
        check("ovf_pc", 32'(bus.pc_in), 32'h051);
        tick();
        idle();
        check("ovf_err", 32'(bus.stack_error), 32'd1);
        check("ovf_still_full", 32'(bus.stack_full), 32'd1);
        tick();
        do_reset();
        m_pc = 12'h007;
        do_ret();
        check("unf_pc", 32'(bus.pc_in), 32'h008);
        tick();
        idle();
        check("unf_err", 32'(bus.stack_error), 32'd1);
        tick();

        // Stall beats everything; ret beats call.
        do_reset();
        m_pc = 12'h040;
        do_call(12'h080); tick();
        apply(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 12'h123, 1'b1, 1'b0);
        check("stall_pc", 32'(bus.pc_in), 32'h080);
        tick();
        apply(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 12'h200, 1'b0, 1'b0);
        check("callret_pc", 32'(bus.pc_in), 32'h041);
        tick();
        idle();
        check("callret_empty", 32'(bus.stack_empty), 32'd1);
        check("stall_count", 32'(bus.cycle_count), 32'd2);
        tick();

        // Halt is absorbing until reset.
        do_reset();
        m_pc = 12'h020;
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("halt_pc", 32'(bus.pc_in), 32'h020);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 12'h3AB, 1'b0, 1'b0);
            check("halted_hold", 32'(bus.pc_in), 32'h020);
            check("halted_flag", 32'(bus.halted), 32'd1);
            check("halted_count", 32'(bus.cycle_count), 32'd0);
            tick();
        end

        // Reset mid-operation with depth 3 and error set.
        do_reset();
        do_ret(); tick();
        do_call(12'h111); tick();
        do_call(12'h222); tick();
        do_call(12'h333); tick();
        apply(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h444, 1'b0, 1'b0);
        check("mid_err_before", 32'(bus.stack_error), 32'd1);
        check("mid_rst_pc", 32'(bus.pc_in), 32'h0);
        tick();
        idle();
        check("mid_halted", 32'(bus.halted), 32'd0);
        check("mid_empty", 32'(bus.stack_empty), 32'd1);
        check("mid_full", 32'(bus.stack_full), 32'd0);
        check("mid_err", 32'(bus.stack_error), 32'd0);
        check("mid_count", 32'(bus.cycle_count), 32'd0);
        tick();

        // Random request mixes.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(63) == 0), ($urandom_range(3) == 0), OFFW'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(4) == 0), D'($urandom), ($urandom_range(7) == 0),
                  ($urandom_range(99) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Next-PC selection and control-flow unit feeding the `program_counter` block. It consumes `pc_out` and `pc_added` and produces `pc_in`, selecting among:

- sequential fetch
- PC-relative branch
- absolute jump
- call/return through a small hardware return-address stack
- stall hold
- permanent halt

It owns the fetch-side control state: the RUN/HALTED state, return stack, sticky stack error and retired-cycle counter.

## Interface
Parameters:
- D, 12, PC/address width in bits
- DEPTH, 4, return-stack entries (power of two, ≥2)
- OFFW, 8, width of signed branch offset
- CW, 16, cycle-counter width

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- pc_out  input  D  current PC from program_counter
- pc_added  input  D  pc_out+1 from program_counter
- branch  input  1  take PC-relative branch this cycle
- branch_offset  input  OFFW  signed offset, two's complement
- jump  input  1  absolute jump to jump_target
- call  input  1  push pc_added, go to jump_target
- ret  input  1  pop stack top into PC
- jump_target  input  D  absolute target for jump/call
- stall  input  1  hold PC this cycle
- halt_req  input  1  enter HALTED
- pc_in  output  D  next PC to program_counter (combinational)
- halted  output  1  registered, 1 in HALTED
- stack_empty  output  1  registered-state derived, 1 when depth==0
- stack_full  output  1  1 when depth==DEPTH
- stack_error  output  1  sticky overflow/underflow flag
- cycle_count  output  CW  retired (non-stall, RUN) cycles

## Operation
State machine, 2 states:
- RUN: the next-PC source is chosen by priority (first match wins):
  - halt_req → HALTED
  - stall
  - ret
  - call
  - jump
  - branch
  - sequential
- HALTED: absorbing; only reset leaves it.

pc_in selection:
- reset asserted: 0.
- HALTED, or halt_req in RUN: pc_out. Halting instruction not retired.
- stall: pc_out. No stack change, no count.
- ret, stack non-empty:
  - pc_in = top entry; pop.
- ret, stack empty:
  - pc_in = pc_added; stack_error ← 1.
- call, stack not full:
  - pc_in = jump_target; push pc_added.
- call, stack full:
  - pc_in = pc_added; no push; stack_error ← 1.
- jump: jump_target.
- branch: pc_out + sign_extend(branch_offset) truncated to D bits. Wraps modulo 2^D in both directions.
- otherwise: pc_added (wrap from 2^D−1 to 0 is supplied by program_counter, passed through unchanged).

Return stack:
- DEPTH×D register array, depth counter 0..DEPTH.
- LIFO; at most one push or pop per cycle.
- Contents past depth are don't-care.

cycle_count:
- Increments by 1 on every RUN cycle that is not a stall and not a halt_req cycle.
- This includes error cycles.
- Wraps at 2^CW.

stack_error:
- Set only as specified above.
- Cleared only by reset.

## Timing
- pc_in is combinational from current inputs and state. program_counter registers it on the same rising edge, so the redirect takes effect one edge later (zero-bubble).
- Stack, depth, state, counter and error update on the rising edge using the same priority decision that drove pc_in.
- Reset values:
  - halted=0, depth=0 (stack_empty=1, stack_full=0)
  - stack_error=0, cycle_count=0
  - pc_in=0 while reset is high
- Reset mid-operation (any state, any stack depth) restores all of the above on the next edge. Inputs during the reset cycle are ignored.
- halt_req is sampled in RUN only:
  - halted=1 from the edge after the cycle halt_req was high.
  - pc_in already equals pc_out in that cycle.
- Simultaneous requests resolve strictly by priority. Example: call+ret with depth=2 → pop only, depth=1, no push.
- Push and pop never occur in the same cycle.

## Test plan
- **Reset/sequential:** reset 1 cycle, then 10 cycles of no requests, PC fed back → pc_in walks 1,2,…,10; cycle_count=10; stack_empty=1; halted=0.
- **Branch wrap (D=12):**
  - pc_out=0x002, offset=−4 → pc_in=0xFFE.
  - pc_out=0xFFE, offset=+5 → pc_in=0x003.
  - stack unchanged.
- **Call/return:**
  - at pc=5, call to 0x100 → pc_in=0x100, depth=1.
  - at pc=0x100, call to 0x200 → depth=2.
  - ret → pc_in=0x101.
  - ret → pc_in=6, stack_empty=1, stack_error=0.
- **Overflow/underflow:**
  - 4 calls → stack_full=1.
  - 5th call at pc=0x050 → pc_in=0x051, stack_error=1, depth stays 4.
  - reset, then ret at pc=7 → pc_in=8, stack_error=1.
- **Stall/priority:**
  - stall with jump+call asserted → pc_in=pc_out, depth and cycle_count unchanged.
  - next cycle call+ret with depth=1 → pop wins, depth=0.
- **Halt and reset mid-operation:**
  - halt_req at pc=0x020 → pc_in=0x020, then halted=1.
  - 5 cycles with jump asserted → pc_in stays pc_out, cycle_count frozen.
  - reset with depth=3, error=1 → all outputs return to reset values.
